// File: rtl/credit_rx_port.sv
// Receive side of a credit-based flit link: buffers incoming flits in a small
// FIFO, presents them downstream with valid/ready, and returns one credit
// pulse per flit drained so the sender can re-arm.
module credit_rx_port #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] datain,
    input  logic              in_valid,
    output logic              co,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W:0]    occupancy,
    output logic              overflow
);

    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic              co_q;
    logic              ovf_q;

    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Handshake decode; a full FIFO still accepts a flit when a slot frees this cycle.
    always_comb begin
        full = (occ_q == OCC_W'(DEPTH));
        pop  = (occ_q != '0) && out_ready;
        push = in_valid && (!full || pop);
        drop = in_valid && full && !pop;
    end

    // Flit storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (RST && push) begin
            mem[wr_ptr] <= datain;
        end
    end

    // Pointers, fill level, credit pulse and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - OCC_W'(1);
            end
            co_q <= pop;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Head of FIFO is read straight from storage; no write-to-read bypass.
    always_comb begin
        dataout   = mem[rd_ptr];
        out_valid = (occ_q != '0);
        occupancy = occ_q;
        co        = co_q;
        overflow  = ovf_q;
    end

endmodule
